// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with level flags and sticky errors
//
// Purpose: single-clock FIFO of DEPTH = 2**ADDR_W words of DATA_W bits with a
// registered read port (1-cycle latency), write-through while full, and
// sticky overflow/underflow error flags.
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          asynchronous active-low reset
//   wr_en, din     write request and data (one word per cycle)
//   rd_en          read request (one word per cycle)
//   err_clr        synchronous clear of the sticky error flags
//   dout           registered read data, held between reads
//   dout_valid     one-cycle pulse after each accepted read
//   full, empty    count == DEPTH / count == 0
//   almost_full    count >= AF_THRESH
//   almost_empty   count <= AE_THRESH
//   count          number of stored words, 0..DEPTH
//   overflow_err   sticky: a write was rejected
//   underflow_err  sticky: a read was rejected
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = (2 ** ADDR_W) - 2,
    parameter int AE_THRESH = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_THRESH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_err_q, overflow_err_d;
    logic              underflow_err_q, underflow_err_d;

    logic full_w;
    logic empty_w;
    logic rd_acc;
    logic wr_acc;

    // Flags come from the registered count only, so they never depend on
    // the request inputs and line up with the count they describe.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    // No fall-through: a read needs a stored word before this edge.
    assign rd_acc = rd_en && !empty_w;
    // While full, a simultaneous read frees the slot being written.
    assign wr_acc = wr_en && (!full_w || rd_acc);

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        dout_d          = dout_q;
        dout_valid_d    = rd_acc;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        if (wr_en && !wr_acc) begin
            overflow_err_d = 1'b1;
        end else if (err_clr) begin
            overflow_err_d = 1'b0;
        end

        if (rd_en && empty_w) begin
            underflow_err_d = 1'b1;
        end else if (err_clr) begin
            underflow_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    // Storage is not reset; clearing the pointers makes old words
    // unreachable. Writes are blocked while reset is held.
    always_ff @(posedge clock) begin
        if (wr_acc && reset) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign almost_full   = (count_q >= AF_CNT);
    assign almost_empty  = (count_q <= AE_CNT);
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule
